vmem_seq: RTL and testbench

Vector memory access sequencer: the initiator side of the 4-lane data memory port. It accepts one vector load or store command per handshake and breaks it into 4-element beats, one beat per cycle. Each beat drives four lane addresses, write data and a shared write enable into the 4-port data memory. Load data is gathered into a vector response, and a valid/ready response signals completion to the pipeline.

---
 rtl/vmem_pkg.sv | 22 ++
 rtl/vmem_lane_addr.sv | 20 ++
 rtl/vmem_seq.sv | 211 +++++++++++++++++++++
 tb/tb_vmem_seq.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vmem_pkg.sv
// Shared types and helpers for the vector memory access sequencer.
package vmem_pkg;

    localparam int LANES  = 4;
    localparam int BEAT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STORE,
        ST_LOAD,
        ST_DRAIN,
        ST_RESP
    } state_t;

    typedef logic [BEAT_W-1:0] beat_t;

    // Element index of a lane (0-based) within a beat.
    function automatic int elem_idx(input beat_t beat, input int lane);
        return LANES * int'(beat) + lane;
    endfunction

endpackage

// File: rtl/vmem_lane_addr.sv
// Lane address generator: four consecutive word addresses for one beat,
// wrapping modulo 2^ADDR_W.
module vmem_lane_addr
    import vmem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0]             base,
    input  beat_t                         beat,
    output logic [LANES-1:0][ADDR_W-1:0]  addr
);

    always_comb begin
        addr = '0;
        for (int i = 0; i < LANES; i++) begin
            addr[i] = base + ADDR_W'(elem_idx(beat, i));
        end
    end

endmodule

// File: rtl/vmem_seq.sv
// Vector memory access sequencer: splits one load/store command into 4-lane
// beats. Optional beat counter output enabled by VMEM_SEQ_PERF_EN.
module vmem_seq
    import vmem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_BEATS = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_store,
    input  logic [ADDR_W-1:0]                 cmd_base,
    input  logic [$clog2(MAX_BEATS+1)-1:0]    cmd_beats,
    input  logic [4*MAX_BEATS*DATA_W-1:0]     cmd_wdata,
    output logic                              mem_we,
    output logic [ADDR_W-1:0]                 mem_addr1,
    output logic [ADDR_W-1:0]                 mem_addr2,
    output logic [ADDR_W-1:0]                 mem_addr3,
    output logic [ADDR_W-1:0]                 mem_addr4,
    output logic [DATA_W-1:0]                 mem_wd1,
    output logic [DATA_W-1:0]                 mem_wd2,
    output logic [DATA_W-1:0]                 mem_wd3,
    output logic [DATA_W-1:0]                 mem_wd4,
    input  logic [DATA_W-1:0]                 mem_rd1,
    input  logic [DATA_W-1:0]                 mem_rd2,
    input  logic [DATA_W-1:0]                 mem_rd3,
    input  logic [DATA_W-1:0]                 mem_rd4,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic                              rsp_store,
    output logic [4*MAX_BEATS*DATA_W-1:0]     rsp_rdata
`ifdef VMEM_SEQ_PERF_EN
    ,
    output logic [31:0]                       perf_beats
`endif
);

    localparam int CNT_W = $clog2(MAX_BEATS+1);
    localparam int ELEMS = LANES * MAX_BEATS;
    localparam int VEC_W = ELEMS * DATA_W;

    state_t                          state;
    beat_t                           beat;
    beat_t                           nbeats;
    beat_t                           n_clamped;
    beat_t                           next_beat;
    beat_t                           cap_beat;
    logic [ADDR_W-1:0]               base_q;
    logic [ADDR_W-1:0]               next_base;
    logic [VEC_W-1:0]                wdata_q;
    logic [VEC_W-1:0]                wsrc;
    logic [LANES-1:0][ADDR_W-1:0]    next_addr;
    logic [LANES-1:0][ADDR_W-1:0]    addr_q;
    logic [LANES-1:0][DATA_W-1:0]    next_wd;
    logic [LANES-1:0][DATA_W-1:0]    wd_q;
    logic [LANES-1:0][DATA_W-1:0]    rd;
    logic                            accept;
    logic                            last_beat;
    logic                            issue;
    logic                            issue_store;
    logic                            cap_en;

    assign n_clamped = (cmd_beats > CNT_W'(MAX_BEATS)) ? BEAT_W'(MAX_BEATS)
                                                       : BEAT_W'(cmd_beats);
    assign accept    = (state == ST_IDLE) && cmd_valid && cmd_ready;
    assign last_beat = (beat == nbeats - beat_t'(1));
    assign cap_en    = ((state == ST_LOAD) && (beat != '0)) || (state == ST_DRAIN);
    assign cap_beat  = (state == ST_DRAIN) ? beat : beat - beat_t'(1);

    // Outputs are registered, so the beat presented next cycle is computed now;
    // at accept time that is beat 0 taken straight from the command inputs.
    always_comb begin
        next_beat   = beat + beat_t'(1);
        next_base   = base_q;
        wsrc        = wdata_q;
        issue       = ((state == ST_STORE) || (state == ST_LOAD)) && !last_beat;
        issue_store = (state == ST_STORE);
        if (state == ST_IDLE) begin
            next_beat   = '0;
            next_base   = cmd_base;
            wsrc        = cmd_wdata;
            issue       = accept && (n_clamped != '0);
            issue_store = cmd_store;
        end
    end

    vmem_lane_addr #(
        .ADDR_W (ADDR_W)
    ) u_lane_addr (
        .base (next_base),
        .beat (next_beat),
        .addr (next_addr)
    );

    always_comb begin
        next_wd = '0;
        for (int i = 0; i < LANES; i++) begin
            if (elem_idx(next_beat, i) < ELEMS) begin
                next_wd[i] = wsrc[elem_idx(next_beat, i)*DATA_W +: DATA_W];
            end
        end
    end

    assign rd = {mem_rd4, mem_rd3, mem_rd2, mem_rd1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            beat      <= '0;
            nbeats    <= '0;
            base_q    <= '0;
            wdata_q   <= '0;
            mem_we    <= 1'b0;
            addr_q    <= '0;
            wd_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_store <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            mem_we <= 1'b0;
            addr_q <= '0;
            wd_q   <= '0;
            if (issue) begin
                mem_we <= issue_store;
                addr_q <= next_addr;
                wd_q   <= issue_store ? next_wd : '0;
            end
            // Read data lags its address by one cycle, so capture trails issue.
            if (cap_en) begin
                for (int i = 0; i < LANES; i++) begin
                    rsp_rdata[elem_idx(cap_beat, i)*DATA_W +: DATA_W] <= rd[i];
                end
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        rsp_store <= cmd_store;
                        rsp_rdata <= '0;
                        base_q    <= cmd_base;
                        wdata_q   <= cmd_wdata;
                        nbeats    <= n_clamped;
                        beat      <= '0;
                        if (n_clamped == '0) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= cmd_store ? ST_STORE : ST_LOAD;
                        end
                    end
                end
                ST_STORE: begin
                    if (last_beat) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                    end else begin
                        beat <= next_beat;
                    end
                end
                ST_LOAD: begin
                    if (last_beat) begin
                        state <= ST_DRAIN;
                    end else begin
                        beat <= next_beat;
                    end
                end
                ST_DRAIN: begin
                    state     <= ST_RESP;
                    rsp_valid <= 1'b1;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign mem_addr1 = addr_q[0];
    assign mem_addr2 = addr_q[1];
    assign mem_addr3 = addr_q[2];
    assign mem_addr4 = addr_q[3];
    assign mem_wd1   = wd_q[0];
    assign mem_wd2   = wd_q[1];
    assign mem_wd3   = wd_q[2];
    assign mem_wd4   = wd_q[3];

`ifdef VMEM_SEQ_PERF_EN
    // Every cycle spent in STORE or LOAD presents exactly one beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_beats <= '0;
        end else if (((state == ST_STORE) || (state == ST_LOAD)) && (perf_beats != '1)) begin
            perf_beats <= perf_beats + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vmem_seq.sv
// Scoreboard bench for vmem_seq with a registered-read memory model.
module tb_vmem_seq;

    typedef logic [511:0] vec_t;

    typedef struct packed {
        logic              we;
        logic [3:0][31:0]  addr;
        logic [3:0][31:0]  wd;
        int                cyc;
    } beat_exp_t;

    typedef struct packed {
        logic  store;
        vec_t  rdata;
        int    cyc;
        int    stall;
    } rsp_exp_t;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_store;
    logic [31:0] cmd_base;
    logic [2:0]  cmd_beats;
    vec_t        cmd_wdata;
    logic        mem_we;
    logic [31:0] mem_addr1, mem_addr2, mem_addr3, mem_addr4;
    logic [31:0] mem_wd1, mem_wd2, mem_wd3, mem_wd4;
    logic [31:0] mem_rd1, mem_rd2, mem_rd3, mem_rd4;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_store;
    vec_t        rsp_rdata;
`ifdef VMEM_SEQ_PERF_EN
    logic [31:0] perf_beats;
`endif

    beat_exp_t   beat_q[$];
    rsp_exp_t    rsp_q[$];
    logic [31:0] mem_model [logic [31:0]];
    int          cyc;
    int          n_checks;
    int          n_fail;
    int          total_beats;
    int          stall_cnt;
    logic        valid_prev;
    logic        hs_prev;
    vec_t        seq;

    vmem_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_store (cmd_store),
        .cmd_base  (cmd_base),
        .cmd_beats (cmd_beats),
        .cmd_wdata (cmd_wdata),
        .mem_we    (mem_we),
        .mem_addr1 (mem_addr1),
        .mem_addr2 (mem_addr2),
        .mem_addr3 (mem_addr3),
        .mem_addr4 (mem_addr4),
        .mem_wd1   (mem_wd1),
        .mem_wd2   (mem_wd2),
        .mem_wd3   (mem_wd3),
        .mem_wd4   (mem_wd4),
        .mem_rd1   (mem_rd1),
        .mem_rd2   (mem_rd2),
        .mem_rd3   (mem_rd3),
        .mem_rd4   (mem_rd4),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_store (rsp_store),
        .rsp_rdata (rsp_rdata)
`ifdef VMEM_SEQ_PERF_EN
        ,
        .perf_beats (perf_beats)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : 32'd0;
    endfunction

    // Four-port memory with a one-cycle registered read.
    always @(posedge clk) begin
        if (mem_we) begin
            mem_model[mem_addr1] = mem_wd1;
            mem_model[mem_addr2] = mem_wd2;
            mem_model[mem_addr3] = mem_wd3;
            mem_model[mem_addr4] = mem_wd4;
        end
        mem_rd1 <= model_rd(mem_addr1);
        mem_rd2 <= model_rd(mem_addr2);
        mem_rd3 <= model_rd(mem_addr3);
        mem_rd4 <= model_rd(mem_addr4);
    end

    task automatic check_output(input string name, input vec_t actual, input vec_t expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic vec_t vec4(input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] c, input logic [31:0] d);
        vec_t v;
        v = '0;
        v[31:0]   = a;
        v[63:32]  = b;
        v[95:64]  = c;
        v[127:96] = d;
        return v;
    endfunction

    // Offer one command, hold it until accepted, then queue the expected beats
    // and response. With abort set only beat 0 is expected and no response.
    task automatic apply_stimulus(input logic store, input logic [31:0] base,
                                  input logic [2:0] beats, input vec_t wdata,
                                  input vec_t exp_rdata, input int stall, input bit abort);
        int        n;
        int        c;
        int        waited;
        beat_exp_t be;
        rsp_exp_t  re;
        @(negedge clk);
        cmd_store = store;
        cmd_base  = base;
        cmd_beats = beats;
        cmd_wdata = wdata;
        cmd_valid = 1'b1;
        waited    = 0;
        while (!cmd_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            check_output("accept_timeout", vec_t'(cmd_ready), vec_t'(1));
            cmd_valid = 1'b0;
            return;
        end
        c = cyc;
        n = (beats > 3'd4) ? 4 : int'(beats);
        for (int b = 0; b < n; b++) begin
            if (abort && b > 0) break;
            be.we = store;
            for (int i = 0; i < 4; i++) begin
                be.addr[i] = base + 32'(4*b + i);
                be.wd[i]   = store ? wdata[(4*b+i)*32 +: 32] : 32'd0;
            end
            be.cyc = c + 1 + b;
            beat_q.push_back(be);
            total_beats++;
        end
        if (!abort) begin
            re.store = store;
            re.rdata = store ? '0 : exp_rdata;
            re.cyc   = (n == 0) ? c + 1 : (store ? c + n + 1 : c + n + 2);
            re.stall = stall;
            rsp_q.push_back(re);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        while ((rsp_q.size() != 0 || beat_q.size() != 0) && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check_output("idle_timeout_rsp", vec_t'(rsp_q.size()), '0);
        check_output("idle_timeout_beat", vec_t'(beat_q.size()), '0);
        @(negedge clk);
    endtask

    // Memory-side monitor: any non-idle output pattern is a beat.
    always @(negedge clk) begin
        beat_exp_t e;
        if (rst_n && (mem_we || mem_addr1 != 0 || mem_addr2 != 0 ||
                      mem_addr3 != 0 || mem_addr4 != 0 || mem_wd1 != 0)) begin
            if (beat_q.size() == 0) begin
                check_output("unexpected_beat", vec_t'(mem_addr1), '0);
            end else begin
                e = beat_q.pop_front();
                check_output("beat_cycle", vec_t'(cyc), vec_t'(e.cyc));
                check_output("beat_we", vec_t'(mem_we), vec_t'(e.we));
                check_output("beat_addr", vec_t'({mem_addr4, mem_addr3, mem_addr2, mem_addr1}),
                             vec_t'(e.addr));
                check_output("beat_wd", vec_t'({mem_wd4, mem_wd3, mem_wd2, mem_wd1}),
                             vec_t'(e.wd));
            end
        end
    end

    // Response monitor; also drives rsp_ready to apply back-pressure.
    always @(negedge clk) begin
        rsp_exp_t e;
        if (hs_prev) begin
            check_output("cmd_ready_after_hs", vec_t'(cmd_ready), vec_t'(1));
            hs_prev = 1'b0;
        end
        if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
                check_output("unexpected_rsp", vec_t'(rsp_valid), '0);
                rsp_ready = 1'b1;
            end else begin
                e = rsp_q[0];
                if (!valid_prev) begin
                    check_output("rsp_cycle", vec_t'(cyc), vec_t'(e.cyc));
                    check_output("rsp_store", vec_t'(rsp_store), vec_t'(e.store));
                end
                check_output("rsp_rdata", rsp_rdata, e.rdata);
                check_output("cmd_ready_busy", vec_t'(cmd_ready), '0);
                if (stall_cnt < e.stall) begin
                    rsp_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    rsp_ready = 1'b1;
                    stall_cnt = 0;
                    hs_prev   = 1'b1;
                    void'(rsp_q.pop_front());
                end
            end
        end else begin
            rsp_ready = 1'b0;
        end
        valid_prev = rsp_valid;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        total_beats = 0;
        stall_cnt   = 0;
        valid_prev  = 1'b0;
        hs_prev     = 1'b0;
        rsp_ready   = 1'b0;
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_store   = 1'b0;
        cmd_base    = '0;
        cmd_beats   = '0;
        cmd_wdata   = '0;
        seq         = '0;
        for (int e = 0; e < 16; e++) seq[e*32 +: 32] = 32'(1000 + e);

        repeat (3) @(negedge clk);
        check_output("reset_cmd_ready", vec_t'(cmd_ready), vec_t'(1));
        check_output("reset_mem_we", vec_t'(mem_we), '0);
        check_output("reset_addr", vec_t'({mem_addr4, mem_addr3, mem_addr2, mem_addr1}), '0);
        check_output("reset_wd", vec_t'({mem_wd4, mem_wd3, mem_wd2, mem_wd1}), '0);
        check_output("reset_rsp_valid", vec_t'(rsp_valid), '0);
        check_output("reset_rsp_store", vec_t'(rsp_store), '0);
        check_output("reset_rsp_rdata", rsp_rdata, '0);
        rst_n = 1'b1;

        apply_stimulus(1'b1, 32'd0, 3'd1, vec4(50, 100, 11, 23), '0, 0, 1'b0);
        apply_stimulus(1'b0, 32'd0, 3'd1, '0, vec4(50, 100, 11, 23), 0, 1'b0);
        apply_stimulus(1'b1, 32'd8, 3'd4, seq, '0, 0, 1'b0);
        apply_stimulus(1'b0, 32'd8, 3'd4, '0, seq, 3, 1'b0);
        apply_stimulus(1'b1, 32'hFFFF_FFFE, 3'd1, vec4(7, 8, 9, 10), '0, 0, 1'b0);
        apply_stimulus(1'b0, 32'hFFFF_FFFE, 3'd1, '0, vec4(7, 8, 9, 10), 0, 1'b0);
        apply_stimulus(1'b1, 32'd100, 3'd0, vec4(1, 2, 3, 4), '0, 0, 1'b0);
        apply_stimulus(1'b0, 32'd8, 3'd0, '0, '0, 0, 1'b0);
        apply_stimulus(1'b0, 32'd8, 3'd6, '0, seq, 1, 1'b0);
        wait_idle();
`ifdef VMEM_SEQ_PERF_EN
        check_output("perf_beats_total", vec_t'(perf_beats), vec_t'(total_beats));
`endif

        // Abort a 4-beat store while its second beat is on the bus.
        apply_stimulus(1'b1, 32'd40, 3'd4, seq, '0, 0, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_output("abort_mem_we", vec_t'(mem_we), '0);
        check_output("abort_addr", vec_t'(mem_addr1), '0);
        check_output("abort_rsp_valid", vec_t'(rsp_valid), '0);
`ifdef VMEM_SEQ_PERF_EN
        check_output("abort_perf_beats", vec_t'(perf_beats), '0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("abort_cmd_ready", vec_t'(cmd_ready), vec_t'(1));
        check_output("abort_beat0_kept", vec_t'({model_rd(32'd43), model_rd(32'd42),
                     model_rd(32'd41), model_rd(32'd40)}), vec_t'(seq[127:0]));
        check_output("abort_beat1_unwritten", vec_t'(mem_model.exists(32'd44)), '0);
        repeat (5) @(negedge clk);
        check_output("abort_no_rsp", vec_t'(rsp_valid), '0);
        check_output("final_beat_q", vec_t'(beat_q.size()), '0);
        check_output("final_rsp_q", vec_t'(rsp_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
